// File: rtl/recirc_pkg.sv
// Shared encodings and sizing for the parametrised recirculation router.
// Optional per-channel loop counters are enabled with RECIRC_COUNT_EN.
package recirc_pkg;
  localparam int MODE_W     = 2;
  localparam int COUNT_W    = 16;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [MODE_W-1:0] {
    ST_LOOP  = 2'b01,
    ST_FWD   = 2'b10,
    ST_DRAIN = 2'b11
  } state_t;
endpackage

// File: rtl/recirc_skid_buf.sv
// One channel's 2-entry skid FIFO with bypass and registered forward output.
module recirc_skid_buf
  import recirc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data,
  input  logic              pause,
  output logic [1:0]        count,
  output logic              fwd_valid,
  output logic [DATA_W-1:0] fwd_data
);
  localparam logic [1:0] FULL = 2'(SKID_DEPTH);

  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic              pop;
  logic              bypass;
  logic              store;

  assign pop    = !pause && (count != 2'd0);
  assign bypass = !pause && (count == 2'd0);
  // A word that can go straight out is never written into the buffer.
  assign store  = push && (count < FULL) && !bypass;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count     <= 2'd0;
      head      <= '0;
      tail      <= '0;
      fwd_valid <= 1'b0;
      fwd_data  <= '0;
    end else begin
      if (pop) begin
        fwd_valid <= 1'b1;
        fwd_data  <= head;
      end else if (bypass && push) begin
        fwd_valid <= 1'b1;
        fwd_data  <= data;
      end else begin
        fwd_valid <= 1'b0;
      end

      case ({pop, store})
        2'b10: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b01: begin
          if (count == 2'd0) head <= data;
          else               tail <= data;
          count <= count + 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= data;
          end else begin
            head <= tail;
            tail <= data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/recirculacion_param.sv
// N-channel recirculation router: loop path while idle, skid-buffered forward path otherwise.
// Define RECIRC_COUNT_EN to add saturating per-channel loop word counters (loop_count port).
module recirculacion_param
  import recirc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     idle,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH-1:0]        fwd_pause,
  output logic [NUM_CH-1:0]        fwd_valid,
  output logic [NUM_CH*DATA_W-1:0] fwd_data,
  output logic [NUM_CH-1:0]        loop_valid,
  output logic [NUM_CH*DATA_W-1:0] loop_data,
  output logic [MODE_W-1:0]        mode
`ifdef RECIRC_COUNT_EN
  ,
  output logic [NUM_CH*COUNT_W-1:0] loop_count
`endif
);
  localparam logic [1:0] FULL = 2'(SKID_DEPTH);

  state_t            state;
  logic [1:0]        count [NUM_CH];
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] push;

  assign mode   = state;
  assign accept = in_valid & in_ready;
  assign push   = (state == ST_FWD) ? accept : '0;

  always_comb begin
    in_ready = '0;
    empty    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      empty[c] = (count[c] == 2'd0);
      case (state)
        ST_LOOP: in_ready[c] = 1'b1;
        ST_FWD:  in_ready[c] = (count[c] < FULL);
        default: in_ready[c] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= ST_LOOP;
    end else begin
      case (state)
        ST_LOOP:  if (!idle) state <= ST_FWD;
        ST_FWD:   if (idle)  state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!idle)        state <= ST_FWD;
          else if (&empty)  state <= ST_LOOP;
        end
        default:  state <= ST_LOOP;
      endcase
    end
  end

  // Loop path: one-cycle registered echo of words accepted in LOOP mode.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      loop_valid <= '0;
      loop_data  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (state == ST_LOOP && accept[c]) begin
          loop_valid[c]                  <= 1'b1;
          loop_data[c*DATA_W +: DATA_W]  <= in_data[c*DATA_W +: DATA_W];
        end else begin
          loop_valid[c] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    recirc_skid_buf #(.DATA_W(DATA_W)) u_skid (
      .clk       (clk),
      .reset_L   (reset_L),
      .push      (push[g]),
      .data      (in_data[g*DATA_W +: DATA_W]),
      .pause     (fwd_pause[g]),
      .count     (count[g]),
      .fwd_valid (fwd_valid[g]),
      .fwd_data  (fwd_data[g*DATA_W +: DATA_W])
    );
  end

`ifdef RECIRC_COUNT_EN
  logic [COUNT_W-1:0] cnt [NUM_CH];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (state == ST_LOOP && accept[c] && cnt[c] != '1) cnt[c] <= cnt[c] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign loop_count[g*COUNT_W +: COUNT_W] = cnt[g];
  end
`endif
endmodule

// File: tb/tb_recirculacion_param.sv
// Directed self-checking bench for recirculacion_param (4 channels x 8 bits).
module tb_recirculacion_param;
  logic        clk = 1'b0;
  logic        reset_L;
  logic        idle;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic [3:0]  fwd_pause;
  logic [3:0]  fwd_valid;
  logic [31:0] fwd_data;
  logic [3:0]  loop_valid;
  logic [31:0] loop_data;
  logic [1:0]  mode;
`ifdef RECIRC_COUNT_EN
  logic [63:0] loop_count;
`endif

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  recirculacion_param #(.DATA_W(8), .NUM_CH(4)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .idle       (idle),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fwd_pause  (fwd_pause),
    .fwd_valid  (fwd_valid),
    .fwd_data   (fwd_data),
    .loop_valid (loop_valid),
    .loop_data  (loop_data),
    .mode       (mode)
`ifdef RECIRC_COUNT_EN
    ,
    .loop_count (loop_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0; idle = 1'b1; in_valid = '0; in_data = '0; fwd_pause = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_L = 1'b1;
    @(negedge clk); in_valid = 4'hF; in_data = 32'h04030201;
    repeat (3) @(negedge clk);
    reset_L = 1'b0;
    repeat (2) @(negedge clk);
    reset_L = 1'b1; in_valid = '0;
    #1;
    total++; if (mode !== 2'b01) $display("FAIL reset_mode got=%b exp=01", mode); else pass_cnt++;
    total++; if (loop_valid !== 4'h0) $display("FAIL reset_loop_valid got=%h exp=0", loop_valid); else pass_cnt++;
    total++; if (fwd_valid !== 4'h0) $display("FAIL reset_fwd_valid got=%h exp=0", fwd_valid); else pass_cnt++;
    total++; if (in_ready !== 4'hF) $display("FAIL reset_in_ready got=%h exp=F", in_ready); else pass_cnt++;
    total++; if (loop_data !== 32'h0) $display("FAIL reset_loop_data got=%h exp=0", loop_data); else pass_cnt++;
`ifdef RECIRC_COUNT_EN
    total++; if (loop_count !== 64'h0) $display("FAIL reset_loop_count got=%h exp=0", loop_count); else pass_cnt++;
`endif
    tick();
    total++; if (loop_valid !== 4'h0) $display("FAIL reset_idle_loop got=%h exp=0", loop_valid); else pass_cnt++;
  endtask

`ifdef RECIRC_COUNT_EN
  task automatic test_count();
    @(negedge clk); in_valid = 4'b1000; in_data = 32'hAB000000;
    repeat (3) @(negedge clk);
    in_valid = '0;
    #1;
    total++; if (loop_count[63:48] !== 16'd3) $display("FAIL count_three got=%0d exp=3", loop_count[63:48]); else pass_cnt++;
    in_valid = 4'b1000;
    repeat (65537) @(negedge clk);
    in_valid = '0;
    #1;
    total++; if (loop_count[63:48] !== 16'hFFFF) $display("FAIL count_sat got=%h exp=FFFF", loop_count[63:48]); else pass_cnt++;
    total++; if (loop_count[15:0] !== 16'd0) $display("FAIL count_ch0 got=%h exp=0", loop_count[15:0]); else pass_cnt++;
  endtask
`endif

  task automatic test_loop();
    @(negedge clk); idle = 1'b1; in_valid = 4'b0001; in_data = 32'h000000A5;
    tick();
    total++; if (loop_valid !== 4'b0001) $display("FAIL loop_valid got=%b exp=0001", loop_valid); else pass_cnt++;
    total++; if (loop_data[7:0] !== 8'hA5) $display("FAIL loop_data got=%h exp=A5", loop_data[7:0]); else pass_cnt++;
    total++; if (fwd_valid !== 4'h0) $display("FAIL loop_fwd_valid got=%b exp=0", fwd_valid); else pass_cnt++;
    @(negedge clk); in_valid = '0; in_data = 32'h000000FF;
    tick();
    total++; if (loop_valid !== 4'h0) $display("FAIL loop_drop got=%b exp=0", loop_valid); else pass_cnt++;
    total++; if (loop_data[7:0] !== 8'hA5) $display("FAIL loop_hold got=%h exp=A5", loop_data[7:0]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vec [3];
    vec[0] = 32'h44332211; vec[1] = 32'h88776655; vec[2] = 32'hDDCCBBAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 4'hF; in_data = vec[i];
      tick();
      total++; if (loop_valid !== 4'hF) $display("FAIL b2b_valid[%0d] got=%h exp=F", i, loop_valid); else pass_cnt++;
      total++; if (loop_data !== vec[i]) $display("FAIL b2b_data[%0d] got=%h exp=%h", i, loop_data, vec[i]); else pass_cnt++;
    end
    @(negedge clk); in_valid = '0;
  endtask

  task automatic test_fwd_bypass();
    @(negedge clk); idle = 1'b0; in_valid = '0;
    tick();
    total++; if (mode !== 2'b10) $display("FAIL fwd_mode got=%b exp=10", mode); else pass_cnt++;
    @(negedge clk); in_valid = 4'b0100; in_data = 32'h003C0000; fwd_pause = '0;
    total++; if (in_ready !== 4'hF) $display("FAIL fwd_ready got=%h exp=F", in_ready); else pass_cnt++;
    tick();
    total++; if (fwd_valid !== 4'b0100) $display("FAIL fwd_valid got=%b exp=0100", fwd_valid); else pass_cnt++;
    total++; if (fwd_data[23:16] !== 8'h3C) $display("FAIL fwd_data got=%h exp=3C", fwd_data[23:16]); else pass_cnt++;
    total++; if (loop_valid !== 4'h0) $display("FAIL fwd_loop_quiet got=%b exp=0", loop_valid); else pass_cnt++;
    @(negedge clk); in_valid = '0;
    tick();
    total++; if (fwd_valid !== 4'h0) $display("FAIL fwd_idle got=%b exp=0", fwd_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    @(negedge clk); fwd_pause = 4'b0010; in_valid = 4'b0010; in_data = 32'h00001100;
    @(negedge clk); in_data = 32'h00002200;
    total++; if (in_ready[1] !== 1'b1) $display("FAIL bp_ready_one got=%b exp=1", in_ready[1]); else pass_cnt++;
    @(negedge clk); in_valid = '0;
    total++; if (in_ready[1] !== 1'b0) $display("FAIL bp_full got=%b exp=0", in_ready[1]); else pass_cnt++;
    total++; if (fwd_valid[1] !== 1'b0) $display("FAIL bp_paused got=%b exp=0", fwd_valid[1]); else pass_cnt++;
    fwd_pause = '0;
    tick();
    total++; if (fwd_valid[1] !== 1'b1 || fwd_data[15:8] !== 8'h11) $display("FAIL bp_first got=%b/%h exp=1/11", fwd_valid[1], fwd_data[15:8]); else pass_cnt++;
    tick();
    total++; if (fwd_valid[1] !== 1'b1 || fwd_data[15:8] !== 8'h22) $display("FAIL bp_second got=%b/%h exp=1/22", fwd_valid[1], fwd_data[15:8]); else pass_cnt++;
    total++; if (in_ready[1] !== 1'b1) $display("FAIL bp_ready_back got=%b exp=1", in_ready[1]); else pass_cnt++;
    tick();
    total++; if (fwd_valid[1] !== 1'b0) $display("FAIL bp_empty got=%b exp=0", fwd_valid[1]); else pass_cnt++;
  endtask

  task automatic test_drain();
    @(negedge clk); fwd_pause = 4'b0010; in_valid = 4'b0010; in_data = 32'h00003300;
    @(negedge clk); in_data = 32'h00004400;
    @(negedge clk); in_valid = '0; idle = 1'b1;
    tick();
    total++; if (mode !== 2'b11) $display("FAIL drain_mode got=%b exp=11", mode); else pass_cnt++;
    total++; if (in_ready !== 4'h0) $display("FAIL drain_ready got=%h exp=0", in_ready); else pass_cnt++;
    tick();
    total++; if (mode !== 2'b11) $display("FAIL drain_hold got=%b exp=11", mode); else pass_cnt++;
    @(negedge clk); fwd_pause = '0;
    tick();
    total++; if (fwd_valid[1] !== 1'b1 || fwd_data[15:8] !== 8'h33) $display("FAIL drain_first got=%b/%h exp=1/33", fwd_valid[1], fwd_data[15:8]); else pass_cnt++;
    total++; if (loop_valid !== 4'h0) $display("FAIL drain_loop got=%b exp=0", loop_valid); else pass_cnt++;
    tick();
    total++; if (fwd_valid[1] !== 1'b1 || fwd_data[15:8] !== 8'h44) $display("FAIL drain_second got=%b/%h exp=1/44", fwd_valid[1], fwd_data[15:8]); else pass_cnt++;
    total++; if (mode !== 2'b11) $display("FAIL drain_not_yet got=%b exp=11", mode); else pass_cnt++;
    tick();
    total++; if (mode !== 2'b01) $display("FAIL drain_to_loop got=%b exp=01", mode); else pass_cnt++;
    total++; if (fwd_valid !== 4'h0) $display("FAIL drain_done got=%b exp=0", fwd_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
`ifdef RECIRC_COUNT_EN
    test_count();
`endif
    test_loop();
    test_back_to_back();
    test_fwd_bypass();
    test_backpressure();
    test_drain();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
